// File: rtl/npc_commit_pkg.sv
// Shared types for the NPC commit-report path: entry layout and controller states.
// Latency: n/a (types only).
// Backpressure: n/a.
package npc_commit_pkg;

  // Width of pc / nextpc / inst. Every user of commit_entry_t must agree with it.
  localparam int XLEN = 32;

  // One retired instruction as buffered between write-back and the reporter.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] nextpc;
    logic [XLEN-1:0] inst;
  } commit_entry_t;

  // RUN: accept and report. DRAIN: report only. HALTED: idle until reset.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of commit_entry_t; head entry is visible combinationally.
// Latency: an entry written at an edge is at the head no earlier than the next cycle.
// Backpressure: push ignored when full, pop ignored when empty; full is count-based.
// Ports: clock, reset (async active-low), push/push_dat, pop, head_dat, full, empty, count.
module commit_fifo
  import npc_commit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  commit_entry_t push_dat,
  input  logic          pop,
  output commit_entry_t head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  commit_entry_t   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while held in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/commit_report_ctrl.sv
// Sequences retired instructions from write-back into the commit reporter, one record per cycle.
// Latency: one cycle from accepted retirement to earliest record (no bypass).
// Backpressure: in_ready drops when full (no pop-through) or once halting; records pause while rpt_en=0.
// Ports: clock, reset (async active-low); in_valid/in_ready/in_pc/in_nextpc/in_inst from write-back;
//        rpt_en, rpt_valid, rpt_pc/rpt_nextpc/rpt_inst, rpt_seq to the reporter;
//        halt_req, halted, timeout, occupancy for control and status.
module commit_report_ctrl
  import npc_commit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  localparam int CW     = $clog2(DEPTH) + 1,
  localparam int WDW    = $clog2(TIMEOUT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_nextpc,
  input  logic [XLEN-1:0] in_inst,
  input  logic            rpt_en,
  output logic            rpt_valid,
  output logic [XLEN-1:0] rpt_pc,
  output logic [XLEN-1:0] rpt_nextpc,
  output logic [XLEN-1:0] rpt_inst,
  output logic [31:0]     rpt_seq,
  input  logic            halt_req,
  output logic            halted,
  output logic            timeout,
  output logic [CW-1:0]   occupancy
);

  ctrl_state_t     state;
  commit_entry_t   in_entry;
  commit_entry_t   head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [CW-1:0]   occ_after;
  logic [WDW-1:0]  wd_cnt;

  assign in_entry = '{pc: in_pc, nextpc: in_nextpc, inst: in_inst};

  // reset is folded in so both handshakes stay low for the whole reset window.
  assign in_ready  = reset && (state == RUN) && !full;
  assign rpt_valid = reset && !empty && rpt_en && (state != HALTED);
  assign push      = in_valid && in_ready;
  assign pop       = rpt_valid;

  assign rpt_pc     = head.pc;
  assign rpt_nextpc = head.nextpc;
  assign rpt_inst   = head.inst;

  // Occupancy as it will be after this edge; decides DRAIN versus direct HALTED.
  assign occ_after = occupancy + CW'(push) - CW'(pop);

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_dat (in_entry),
    .pop      (pop),
    .head_dat (head),
    .full     (full),
    .empty    (empty),
    .count    (occupancy)
  );

  // Halt sequencing. A push coinciding with halt_req is already counted in occ_after,
  // so that entry is drained like the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            if (occ_after != '0) begin
              state <= DRAIN;
            end else begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (occ_after == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
        default: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // rpt_seq always names the record currently at the head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rpt_seq <= '0;
    end else if (pop) begin
      rpt_seq <= rpt_seq + 32'd1;
    end
  end

  // Watchdog: only stalls with the reporter listening count; a pause (rpt_en=0)
  // freezes the count rather than clearing it. The TIMEOUT-th stalled cycle fires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (pop) begin
      wd_cnt <= '0;
    end else if ((state == RUN) && rpt_en) begin
      if (wd_cnt == WDW'(TIMEOUT - 1)) begin
        timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_report_ctrl.sv
module tb_commit_report_ctrl;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_nextpc;
  logic [31:0] in_inst;
  logic        rpt_en;
  logic        rpt_valid;
  logic [31:0] rpt_pc;
  logic [31:0] rpt_nextpc;
  logic [31:0] rpt_inst;
  logic [31:0] rpt_seq;
  logic        halt_req;
  logic        halted;
  logic        timeout;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  commit_report_ctrl #(
    .XLEN    (32),
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_nextpc  (in_nextpc),
    .in_inst    (in_inst),
    .rpt_en     (rpt_en),
    .rpt_valid  (rpt_valid),
    .rpt_pc     (rpt_pc),
    .rpt_nextpc (rpt_nextpc),
    .rpt_inst   (rpt_inst),
    .rpt_seq    (rpt_seq),
    .halt_req   (halt_req),
    .halted     (halted),
    .timeout    (timeout),
    .occupancy  (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; checks happen at the falling edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid  = v;
    in_pc     = pc;
    in_nextpc = pc + 32'd4;
    in_inst   = pc ^ 32'h0000_0013;
  endtask

  task automatic do_reset;
    reset    = 1'b0;
    halt_req = 1'b0;
    rpt_en   = 1'b0;
    drive(1'b0, 32'h0);
    at_neg;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_seq",       64'(rpt_seq),   64'd0);
    chk("rst_halted",    64'(halted),    64'd0);
    chk("rst_timeout",   64'(timeout),   64'd0);
    chk("rst_pc",        64'(rpt_pc),    64'd0);
    at_neg;
    reset = 1'b1;
    tick;
  endtask

  logic [31:0] p [5];

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 5; i++) p[i] = 32'h8000_0000 + 32'(4 * i);
    tick;

    // ---- back-to-back pushes, reporter listening ----
    do_reset;
    rpt_en = 1'b1;
    drive(1'b1, p[0]);
    at_neg;
    chk("s1_ready_c1", 64'(in_ready), 64'd1);
    chk("s1_valid_c1", 64'(rpt_valid), 64'd0);
    tick;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, p[i+1]); else drive(1'b0, 32'h0);
      at_neg;
      chk("s1_valid", 64'(rpt_valid), 64'd1);
      chk("s1_pc",    64'(rpt_pc),    64'(p[i]));
      chk("s1_seq",   64'(rpt_seq),   64'(i));
      chk("s1_occ",   64'(occupancy), 64'd1);
      tick;
    end
    at_neg;
    chk("s1_valid_end", 64'(rpt_valid), 64'd0);
    chk("s1_occ_end",   64'(occupancy), 64'd0);
    chk("s1_seq_end",   64'(rpt_seq),   64'd3);

    // nextpc/inst path on a fresh entry
    tick;
    drive(1'b1, 32'h8000_0100);
    tick;
    drive(1'b0, 32'h0);
    at_neg;
    chk("s1_nextpc", 64'(rpt_nextpc), 64'h8000_0104);
    chk("s1_inst",   64'(rpt_inst),   64'h8000_0113);

    // ---- fill to full with reporter paused ----
    do_reset;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p[i]);
      at_neg;
      chk("s2_ready_fill", 64'(in_ready), 64'd1);
      tick;
    end
    drive(1'b1, p[4]);
    at_neg;
    chk("s2_ready_full", 64'(in_ready),  64'd0);
    chk("s2_occ_full",   64'(occupancy), 64'd4);
    chk("s2_valid_off",  64'(rpt_valid), 64'd0);
    tick;
    rpt_en = 1'b1;
    at_neg;
    chk("s2_no_popthru", 64'(in_ready), 64'd0);
    chk("s2_pc0",        64'(rpt_pc),   64'(p[0]));
    tick;
    at_neg;
    chk("s2_ready_after", 64'(in_ready),  64'd1);
    chk("s2_occ3",        64'(occupancy), 64'd3);
    tick;
    drive(1'b0, 32'h0);
    for (int i = 2; i < 5; i++) begin
      at_neg;
      chk("s2_valid", 64'(rpt_valid), 64'd1);
      chk("s2_pc",    64'(rpt_pc),    64'(p[i]));
      chk("s2_seq",   64'(rpt_seq),   64'(i));
      tick;
    end
    at_neg;
    chk("s2_empty", 64'(occupancy), 64'd0);

    // ---- halt with entries buffered and a simultaneous push ----
    do_reset;
    drive(1'b1, p[0]);
    tick;
    drive(1'b1, p[1]);
    tick;
    drive(1'b1, p[2]);
    halt_req = 1'b1;
    at_neg;
    chk("s3_ready_halt", 64'(in_ready), 64'd1);
    tick;
    halt_req = 1'b0;
    drive(1'b1, p[3]);
    rpt_en = 1'b1;
    at_neg;
    chk("s3_drain_ready", 64'(in_ready),  64'd0);
    chk("s3_occ",         64'(occupancy), 64'd3);
    chk("s3_halted_no",   64'(halted),    64'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) at_neg;
      chk("s3_valid", 64'(rpt_valid), 64'd1);
      chk("s3_pc",    64'(rpt_pc),    64'(p[i]));
      tick;
    end
    at_neg;
    chk("s3_halted",   64'(halted),    64'd1);
    chk("s3_valid_hl", 64'(rpt_valid), 64'd0);
    chk("s3_seq",      64'(rpt_seq),   64'd3);
    tick;
    at_neg;
    chk("s3_ignore_ready", 64'(in_ready),  64'd0);
    chk("s3_ignore_occ",   64'(occupancy), 64'd0);

    // ---- halt with empty FIFO ----
    do_reset;
    rpt_en   = 1'b1;
    halt_req = 1'b1;
    at_neg;
    chk("s4_not_yet", 64'(halted), 64'd0);
    tick;
    halt_req = 1'b0;
    drive(1'b1, p[0]);
    at_neg;
    chk("s4_halted", 64'(halted),    64'd1);
    chk("s4_valid",  64'(rpt_valid), 64'd0);
    chk("s4_ready",  64'(in_ready),  64'd0);
    tick;
    drive(1'b0, 32'h0);
    at_neg;
    chk("s4_valid2", 64'(rpt_valid), 64'd0);

    // ---- watchdog ----
    do_reset;
    for (int i = 0; i < 20; i++) tick;
    at_neg;
    chk("s5_paused_no_to", 64'(timeout), 64'd0);
    tick;
    rpt_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      at_neg;
      if (i == 8) chk("s5_to_edge", 64'(timeout), 64'd0);
      tick;
    end
    at_neg;
    chk("s5_to_set", 64'(timeout), 64'd1);
    drive(1'b1, p[0]);
    tick;
    drive(1'b0, 32'h0);
    tick;
    at_neg;
    chk("s5_to_sticky", 64'(timeout), 64'd1);

    // ---- reset mid-stream ----
    do_reset;
    rpt_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, p[i]);
      tick;
    end
    drive(1'b0, 32'h0);
    tick;
    rpt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h9000_0000 + 32'(4 * i));
      tick;
    end
    drive(1'b0, 32'h0);
    rpt_en = 1'b1;
    at_neg;
    chk("s6_pre_seq",   64'(rpt_seq),   64'd5);
    chk("s6_pre_occ",   64'(occupancy), 64'd3);
    chk("s6_pre_valid", 64'(rpt_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("s6_rst_valid", 64'(rpt_valid), 64'd0);
    chk("s6_rst_occ",   64'(occupancy), 64'd0);
    chk("s6_rst_seq",   64'(rpt_seq),   64'd0);
    at_neg;
    reset = 1'b1;
    tick;
    drive(1'b1, 32'hA000_0000);
    tick;
    drive(1'b0, 32'h0);
    at_neg;
    chk("s6_post_valid", 64'(rpt_valid), 64'd1);
    chk("s6_post_pc",    64'(rpt_pc),    64'hA000_0000);
    chk("s6_post_seq",   64'(rpt_seq),   64'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
